alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Execute-stage controller for the 16-bit ALU datapath.
- Accepts one decoded instruction per handshake and drives registered ALU operand-control signals (invA, invB, Cin) into the EX stage.
- Sequences the multi-cycle shift-add multiply through the shared ALU adder (16 step cycles).
- Back-pressures the ID stage while busy; honours pipeline flush.

Parameters:
- OPW, 5, opcode field width (instr[15:11]).
- MUL_OPC, 5'b00011, opcode of the iterative multiply.
- MUL_STEPS, 16, adder passes per multiply; counter width is clog2(MUL_STEPS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard in-flight op (branch mispredict/exception)
- in_valid  in  1  ID stage presents instr
- in_ready  out  1  controller accepts instr this cycle
- instr  in  16  instruction word
- out_valid  out  1  EX control/result valid
- out_ready  in  1  downstream (EX/MEM) accepts
- invA  out  1  invert ALU operand A
- invB  out  1  invert ALU operand B
- Cin  out  1  ALU carry-in
- mul_step  out  1  multiply datapath performs one add/shift this cycle
- mul_first  out  1  first multiply step (load partial product = 0)
- busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE; step counter 0.
- Decode rules (all other opcodes: invA=invB=Cin=0):
  - ANDNI, 01011: invB=1, Cin=0.
  - ANDN, 11011 with funct instr[1:0]=11: invB=1, Cin=0.
  - SUBI, 01001: invA=1, Cin=1.
  - SUB, 11011 with funct 01: invA=1, Cin=1.
  - MUL_OPC: invA=invB=Cin=0 on every step.
- Accept occurs on in_valid & in_ready. Control outputs are registered and appear the cycle after accept (latency 1).
- FSM states:
  - IDLE: in_ready=1. Accept non-MUL -> ISSUE. Accept MUL -> MUL.
  - ISSUE: out_valid=1; outputs held stable until out_ready. in_ready=out_ready, so back-to-back issue is allowed. On out_ready: new accept -> ISSUE or MUL; no accept -> IDLE.
  - MUL: in_ready=0, out_valid=0, mul_step=1 each cycle. mul_first=1 only when counter=0. Counter increments; when counter reaches MUL_STEPS-1 -> DONE, counter cleared.
  - DONE: out_valid=1, mul_step=0. Holds until out_ready; then behaves as ISSUE exit.
- A multiply occupies exactly MUL_STEPS+1 cycles before the earliest possible out_valid handshake completes; the +1 is the DONE cycle.
- out_valid must never drop, and invA/invB/Cin must never change, while out_valid=1 and out_ready=0.
- flush: highest priority after rst. Next state IDLE; out_valid, mul_step and mul_first cleared; counter cleared. Any instr presented in the same cycle is not accepted (in_ready forced 0 while flush=1).
- rst mid-multiply: same as flush plus all outputs to reset values.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro ALU_ISSUE_CTRL_PERF_EN.
- Defined: adds outputs perf_issue[15:0] (counts completed out handshakes) and perf_stall[15:0] (counts cycles with in_valid=1, in_ready=0). Both wrap at 16'hFFFF->0, clear on rst, and are not cleared by flush.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode constants OPC_ANDNI, OPC_ANDN_R (11011), OPC_SUBI, OPC_MUL;
  - funct constants FN_SUB=2'b01, FN_ANDN=2'b11;
  - state enum {IDLE, ISSUE, MUL, DONE}.
- One combinational sub-module, alu_issue_dec: instr -> {invA, invB, Cin, is_mul}. The controller registers its outputs on accept.

Test Plan:
- After rst, SUB 16'hD801 with in_valid=1, out_ready=1 -> next cycle out_valid=1, invA=1, invB=0, Cin=1.
- ANDNI 16'h5800, then ANDN 16'hD803 back-to-back, out_ready=1 -> two consecutive out_valid cycles, each invB=1, Cin=0, invA=0; in_ready stays 1.
- SUBI 16'h4800 with out_ready=0 for 3 cycles -> out_valid, invA=1, Cin=1 held stable; in_ready=0 until out_ready=1.
- MUL 16'h1800 -> mul_first=1 in cycle 1 only; mul_step=1 for 16 cycles; out_valid=1 at cycle 17; in_ready=0 throughout.
- flush asserted at multiply step 7 with in_valid=1 -> next cycle IDLE, mul_step=0, out_valid=0, presented instr not accepted.
- ADD 16'hD800 (funct 00) -> invA=invB=Cin=0. With ALU_ISSUE_CTRL_PERF_EN defined, perf_issue increments by 1 per handshake.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared opcode/funct constants and FSM state type for the ALU issue controller.
package alu_issue_pkg;

  localparam int unsigned OPW_DEF = 5;

  localparam logic [4:0] OPC_ANDNI  = 5'b01011;
  localparam logic [4:0] OPC_ANDN_R = 5'b11011;
  localparam logic [4:0] OPC_SUBI   = 5'b01001;
  localparam logic [4:0] OPC_MUL    = 5'b00011;

  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_ANDN = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MUL,
    DONE
  } state_e;

  // Counter width for a given step count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decode of an instruction word into ALU operand controls.
module alu_issue_dec
  import alu_issue_pkg::*;
#(
  parameter int unsigned     OPW     = OPW_DEF,
  parameter logic [OPW-1:0]  MUL_OPC = OPW'(OPC_MUL)
) (
  input  logic [15:0] instr,
  output logic        invA,
  output logic        invB,
  output logic        Cin,
  output logic        is_mul
);

  logic [OPW-1:0] opc;
  logic [1:0]     funct;
  logic           unused_mid;

  assign opc        = instr[15 -: OPW];
  assign funct      = instr[1:0];
  assign unused_mid = ^instr[15-OPW:2];

  always_comb begin
    invA   = 1'b0;
    invB   = 1'b0;
    Cin    = 1'b0;
    is_mul = 1'b0;
    // Multiply takes priority so its steps always run with plain adder controls.
    if (opc == MUL_OPC) begin
      is_mul = 1'b1;
    end else if (opc == OPW'(OPC_ANDNI)) begin
      invB = 1'b1;
    end else if (opc == OPW'(OPC_SUBI)) begin
      invA = 1'b1;
      Cin  = 1'b1;
    end else if (opc == OPW'(OPC_ANDN_R)) begin
      if (funct == FN_ANDN) begin
        invB = 1'b1;
      end else if (funct == FN_SUB) begin
        invA = 1'b1;
        Cin  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller with iterative shift-add multiply sequencing.
// Optional performance counters enabled by defining ALU_ISSUE_CTRL_PERF_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned    OPW       = OPW_DEF,
  parameter logic [OPW-1:0] MUL_OPC   = OPW'(OPC_MUL),
  parameter int unsigned    MUL_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        invA,
  output logic        invB,
  output logic        Cin,
  output logic        mul_step,
  output logic        mul_first,
  output logic        busy
`ifdef ALU_ISSUE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_issue,
  output logic [15:0] perf_stall
`endif
);

  localparam int unsigned CNTW = cnt_width(MUL_STEPS);

  state_e          state;
  logic [CNTW-1:0] cnt;
  logic            accept;
  logic            dec_inva;
  logic            dec_invb;
  logic            dec_cin;
  logic            dec_mul;

  alu_issue_dec #(
    .OPW     (OPW),
    .MUL_OPC (MUL_OPC)
  ) u_dec (
    .instr  (instr),
    .invA   (dec_inva),
    .invB   (dec_invb),
    .Cin    (dec_cin),
    .is_mul (dec_mul)
  );

  // A result slot frees up in the same cycle it is consumed, allowing back-to-back issue.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      unique case (state)
        IDLE:        in_ready = 1'b1;
        ISSUE, DONE: in_ready = out_ready;
        default:     in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      invA      <= 1'b0;
      invB      <= 1'b0;
      Cin       <= 1'b0;
      mul_step  <= 1'b0;
      mul_first <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      invA      <= 1'b0;
      invB      <= 1'b0;
      Cin       <= 1'b0;
      mul_step  <= 1'b0;
      mul_first <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // accept implies the previous result (if any) was consumed this cycle
      state     <= dec_mul ? MUL : ISSUE;
      cnt       <= '0;
      out_valid <= ~dec_mul;
      invA      <= dec_inva;
      invB      <= dec_invb;
      Cin       <= dec_cin;
      mul_step  <= dec_mul;
      mul_first <= dec_mul;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
        end
        ISSUE, DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            invA      <= 1'b0;
            invB      <= 1'b0;
            Cin       <= 1'b0;
            busy      <= 1'b0;
          end
        end
        MUL: begin
          mul_first <= 1'b0;
          if (cnt == CNTW'(MUL_STEPS - 1)) begin
            state     <= DONE;
            cnt       <= '0;
            mul_step  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            mul_step <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_CTRL_PERF_EN
  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready) begin
        perf_issue <= perf_issue + 16'd1;
      end
      if (in_valid && !in_ready) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl (decode table plus multi-cycle sequences).
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        invA;
  logic        invB;
  logic        Cin;
  logic        mul_step;
  logic        mul_first;
  logic        busy;
`ifdef ALU_ISSUE_CTRL_PERF_EN
  logic [15:0] perf_issue;
  logic [15:0] perf_stall;
  logic [15:0] snap;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .invA      (invA),
    .invB      (invB),
    .Cin       (Cin),
    .mul_step  (mul_step),
    .mul_first (mul_first),
    .busy      (busy)
`ifdef ALU_ISSUE_CTRL_PERF_EN
    ,
    .perf_issue(perf_issue),
    .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [15:0] instr;
    logic        inva;
    logic        invb;
    logic        cin;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{16'hD801, 1'b1, 1'b0, 1'b1};  // SUB
    vecs[1] = '{16'h4800, 1'b1, 1'b0, 1'b1};  // SUBI
    vecs[2] = '{16'h5800, 1'b0, 1'b1, 1'b0};  // ANDNI
    vecs[3] = '{16'hD803, 1'b0, 1'b1, 1'b0};  // ANDN
    vecs[4] = '{16'hD800, 1'b0, 1'b0, 1'b0};  // ADD funct 00
    vecs[5] = '{16'hD802, 1'b0, 1'b0, 1'b0};  // funct 10
    vecs[6] = '{16'h5803, 1'b0, 1'b1, 1'b0};  // ANDNI ignores funct
    vecs[7] = '{16'h4FFF, 1'b1, 1'b0, 1'b1};  // SUBI with all low bits set
    vecs[8] = '{16'hFFFF, 1'b0, 1'b0, 1'b0};  // opcode 11111
    vecs[9] = '{16'h0000, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_invA", invA, 0);
    chk("rst_invB", invB, 0);
    chk("rst_Cin", Cin, 0);
    chk("rst_mul_step", mul_step, 0);
    chk("rst_mul_first", mul_first, 0);
    chk("rst_busy", busy, 0);

    // Decode table: single issue from IDLE with downstream always ready.
    for (int i = 0; i < 10; i++) begin
`ifdef ALU_ISSUE_CTRL_PERF_EN
      snap = perf_issue;
`endif
      in_valid  = 1'b1;
      instr     = vecs[i].instr;
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_invA", i), invA, vecs[i].inva);
      chk($sformatf("v%0d_invB", i), invB, vecs[i].invb);
      chk($sformatf("v%0d_Cin", i), Cin, vecs[i].cin);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_mul_step", i), mul_step, 0);
      tick();
      chk($sformatf("v%0d_idle_valid", i), out_valid, 0);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
`ifdef ALU_ISSUE_CTRL_PERF_EN
      chk($sformatf("v%0d_perf_issue", i), perf_issue, 32'(snap + 16'd1));
`endif
    end

    // Back-to-back ANDNI then ANDN.
    in_valid  = 1'b1;
    instr     = 16'h5800;
    out_ready = 1'b1;
    tick();
    instr = 16'hD803;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_v1", out_valid, 1);
    chk("b2b_invB1", invB, 1);
    chk("b2b_invA1", invA, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b_v2", out_valid, 1);
    chk("b2b_invB2", invB, 1);
    chk("b2b_invA2", invA, 0);
    chk("b2b_Cin2", Cin, 0);
    tick();
    chk("b2b_end", out_valid, 0);

    // SUBI stalled by downstream for 3 cycles while ID keeps presenting.
`ifdef ALU_ISSUE_CTRL_PERF_EN
    snap = perf_stall;
`endif
    in_valid  = 1'b1;
    instr     = 16'h4800;
    out_ready = 1'b0;
    tick();
    instr = 16'hD803;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
      chk($sformatf("stall%0d_valid", c), out_valid, 1);
      chk($sformatf("stall%0d_invA", c), invA, 1);
      chk($sformatf("stall%0d_invB", c), invB, 0);
      chk($sformatf("stall%0d_Cin", c), Cin, 1);
      tick();
    end
`ifdef ALU_ISSUE_CTRL_PERF_EN
    chk("perf_stall", perf_stall, 32'(snap + 16'd3));
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1);
    chk("stall_release_invA", invA, 1);
    tick();
    chk("stall_end", out_valid, 0);

    // Multiply: 16 step cycles, then DONE held for 2 cycles of back-pressure.
    in_valid  = 1'b1;
    instr     = 16'h1800;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk($sformatf("mul%0d_step", c), mul_step, 1);
      chk($sformatf("mul%0d_first", c), mul_first, (c == 1) ? 1 : 0);
      chk($sformatf("mul%0d_valid", c), out_valid, 0);
      chk($sformatf("mul%0d_in_ready", c), in_ready, 0);
      chk($sformatf("mul%0d_busy", c), busy, 1);
      chk($sformatf("mul%0d_inv", c), {invA, invB, Cin}, 0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("done%0d_valid", c), out_valid, 1);
      chk($sformatf("done%0d_step", c), mul_step, 0);
      chk($sformatf("done%0d_in_ready", c), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("done_release_ready", in_ready, 1);
    tick();
    chk("mul_end_valid", out_valid, 0);
    chk("mul_end_busy", busy, 0);

    // Flush during step 7 while a new instruction is presented.
    in_valid = 1'b1;
    instr    = 16'h1800;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    chk("fl_pre_step", mul_step, 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 16'hD801;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_step", mul_step, 0);
    chk("fl_first", mul_first, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_ready", in_ready, 1);
    tick();
    chk("fl_no_accept", out_valid, 0);

    // Fresh multiply after flush must restart the step count.
    in_valid = 1'b1;
    instr    = 16'h1800;
    tick();
    in_valid = 1'b0;
    chk("fl_restart_first", mul_first, 1);
    for (int c = 1; c < 16; c++) tick();
    chk("fl_restart_last_step", mul_step, 1);
    tick();
    chk("fl_restart_done", out_valid, 1);
    tick();

    // Reset mid-multiply.
    in_valid = 1'b1;
    instr    = 16'h1800;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstm_step", mul_step, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_ready", in_ready, 1);
`ifdef ALU_ISSUE_CTRL_PERF_EN
    chk("rstm_perf_issue", perf_issue, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
